// File: rtl/data_memory_mc.sv
// data_memory_mc: byte-addressed little-endian data memory with a
// valid/ready request side and a fixed-latency one-cycle response strobe.
// Optional build macro: DMEM_MISALIGN_TRAP_EN makes misaligned halfword and
// word accesses fault instead of being performed byte-wise with wrap.
module data_memory_mc #(
    parameter int N       = 8,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          WE,
    input  logic [2:0]    funct3,
    input  logic [N-1:0]  A,
    input  logic [31:0]   WD,
    output logic          rsp_valid,
    output logic [31:0]   RD,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int          LOAD_V     = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0]  COUNT_LOAD = 4'(LOAD_V);

    state_t       r_state;
    state_t       w_next_state;
    logic [3:0]   r_count;
    logic [3:0]   w_next_count;

    logic         r_we;
    logic [2:0]   r_funct3;
    logic [N-1:0] r_addr;
    logic [31:0]  r_wd;
    logic [31:0]  r_rd;
    logic         r_err;

    logic [7:0]   r_mem [0:(2**N)-1];

    logic         w_accept;
    logic         w_commit;
    logic         w_op_we;
    logic [2:0]   w_op_f3;
    logic [N-1:0] w_op_addr;
    logic [31:0]  w_op_wd;
    logic [N-1:0] w_a1;
    logic [N-1:0] w_a2;
    logic [N-1:0] w_a3;
    logic [7:0]   w_b0;
    logic [7:0]   w_b1;
    logic [7:0]   w_b2;
    logic [7:0]   w_b3;
    logic         w_illegal;
    logic         w_unsigned;
    logic [1:0]   w_size;
    logic         w_fault;
    logic [31:0]  w_load_data;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign RD        = r_rd;
    assign err       = r_err;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_commit  = (w_next_state == RESP);

    // With zero latency the commit edge is the accept edge, so the live
    // inputs are used there; otherwise the captured request is used.
    assign w_op_we   = (r_state == IDLE) ? WE     : r_we;
    assign w_op_f3   = (r_state == IDLE) ? funct3 : r_funct3;
    assign w_op_addr = (r_state == IDLE) ? A      : r_addr;
    assign w_op_wd   = (r_state == IDLE) ? WD     : r_wd;

    assign w_a1 = w_op_addr + N'(1);
    assign w_a2 = w_op_addr + N'(2);
    assign w_a3 = w_op_addr + N'(3);

    assign w_b0 = r_mem[w_op_addr];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_fault = w_illegal
                   | ((w_size == 2'd1) && w_op_addr[0])
                   | ((w_size == 2'd2) && (w_op_addr[1:0] != 2'b00));
`else
    assign w_fault = w_illegal;
`endif

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // Next-state logic: IDLE -> WAIT (or RESP at zero latency) -> RESP -> IDLE.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        w_next_state = RESP;
                        w_next_count = 4'd0;
                    end else begin
                        w_next_state = WAIT;
                        w_next_count = COUNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_count == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_count = 4'd0;
            end
        endcase
    end

    // Capture the request on the accept edge; inputs are free afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wd     <= 32'd0;
        end else if (w_accept) begin
            r_we     <= WE;
            r_funct3 <= funct3;
            r_addr   <= A;
            r_wd     <= WD;
        end
    end

    // Decode funct3 into access size, signedness and legality.
    always_comb begin
        w_illegal  = 1'b0;
        w_unsigned = 1'b0;
        w_size     = 2'd0;
        case (w_op_f3)
            3'b000: w_size = 2'd0;
            3'b001: w_size = 2'd1;
            3'b010: w_size = 2'd2;
            3'b100: begin
                w_size     = 2'd0;
                w_unsigned = 1'b1;
                w_illegal  = w_op_we;
            end
            3'b101: begin
                w_size     = 2'd1;
                w_unsigned = 1'b1;
                w_illegal  = w_op_we;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Assemble and extend load data from the little-endian byte lanes.
    always_comb begin
        w_load_data = 32'd0;
        case (w_size)
            2'd0: w_load_data = w_unsigned ? {24'd0, w_b0}
                                           : {{24{w_b0[7]}}, w_b0};
            2'd1: w_load_data = w_unsigned ? {16'd0, w_b1, w_b0}
                                           : {{16{w_b1[7]}}, w_b1, w_b0};
            default: w_load_data = {w_b3, w_b2, w_b1, w_b0};
        endcase
    end

    // Response registers update on the edge entering RESP and then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd  <= 32'd0;
            r_err <= 1'b0;
        end else if (w_commit) begin
            r_err <= w_fault;
            r_rd  <= (w_op_we || w_fault) ? 32'd0 : w_load_data;
        end
    end

    // Store commit on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && w_op_we && !w_fault) begin
            r_mem[w_op_addr] <= w_op_wd[7:0];
            if (w_size != 2'd0) begin
                r_mem[w_a1] <= w_op_wd[15:8];
            end
            if (w_size == 2'd2) begin
                r_mem[w_a2] <= w_op_wd[23:16];
                r_mem[w_a3] <= w_op_wd[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mc.sv
// tb_data_memory_mc: directed self-checking bench for data_memory_mc with
// N=8, LATENCY=2. Follows DMEM_MISALIGN_TRAP_EN for the misalignment scenario.
module tb_data_memory_mc;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        WE;
    logic [2:0]  funct3;
    logic [7:0]  A;
    logic [31:0] WD;
    logic        rsp_valid;
    logic [31:0] RD;
    logic        err;

    int errors = 0;
    int checks = 0;

    data_memory_mc #(.N(8), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .WE        (WE),
        .funct3    (funct3),
        .A         (A),
        .WD        (WD),
        .rsp_valid (rsp_valid),
        .RD        (RD),
        .err       (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one request from a negedge in IDLE and wait for its response.
    // lat counts clock edges from the accept edge to the edge closing RESP.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output logic one_cycle);
        WE = we; funct3 = f3; A = a; WD = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        WE = 1'b0; funct3 = 3'b000; A = 8'h00; WD = 32'h0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        rd = RD;
        er = err;
        @(negedge clk);
        one_cycle = !rsp_valid && req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; WE = 1'b0; funct3 = 3'b000; A = 8'h00; WD = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rsp_valid, RD, err} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rsp_valid=%b RD=%h err=%b, want 0/0/0", rsp_valid, RD, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er; logic oc;
        do_req(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, lat, rd, er, oc);
        checks++;
        if (lat !== 3 || oc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_timing: got lat=%0d one_cycle=%b, want 3/1", lat, oc);
        end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sw_rsp: got RD=%h err=%b, want 00000000/0", rd, er);
        end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (lat !== 3 || oc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lw_timing: got lat=%0d one_cycle=%b, want 3/1", lat, oc);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_data: got RD=%h err=%b, want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [7:0]  adr [4] = '{8'h13, 8'h13, 8'h10, 8'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
        int lat; logic [31:0] rd; logic er; logic oc;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adr[i], 32'h0, lat, rd, er, oc);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("[TB] FAIL load_ext[%0d]: got RD=%h err=%b, want %h/0", i, rd, er, exp[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        int lat; logic [31:0] rd; logic er; logic oc;
        do_req(1'b1, 3'b000, 8'h11, 32'h12345677, lat, rd, er, oc);
        do_req(1'b0, 3'b010, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'hDEAD77EF) begin
            errors++;
            $display("[TB] FAIL sb_merge: got RD=%h, want dead77ef", rd);
        end
        do_req(1'b1, 3'b001, 8'h12, 32'hFFFF1234, lat, rd, er, oc);
        do_req(1'b0, 3'b010, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h123477EF) begin
            errors++;
            $display("[TB] FAIL sh_merge: got RD=%h, want 123477ef", rd);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er; logic oc;
        do_req(1'b0, 3'b011, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_load: got RD=%h err=%b, want 00000000/1", rd, er);
        end
        do_req(1'b1, 3'b100, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (er !== 1'b1 || lat !== 3) begin
            errors++;
            $display("[TB] FAIL illegal_store: got err=%b lat=%0d, want 1/3", er, lat);
        end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h123477EF || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_nowrite: got RD=%h err=%b, want 123477ef/0", rd, er);
        end
    endtask

`ifdef DMEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int lat; logic [31:0] rd; logic er; logic oc;
        do_req(1'b0, 3'b010, 8'h11, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_lw: got RD=%h err=%b, want 00000000/1", rd, er);
        end
        do_req(1'b1, 3'b001, 8'h11, 32'hFFFFAAAA, lat, rd, er, oc);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_sh: got err=%b, want 1", er);
        end
        do_req(1'b0, 3'b010, 8'h10, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h123477EF) begin
            errors++;
            $display("[TB] FAIL misalign_nowrite: got RD=%h, want 123477ef", rd);
        end
    endtask
`else
    task automatic test_misalign();
        logic [7:0] badr [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};
        logic [7:0] bexp [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        int lat; logic [31:0] rd; logic er; logic oc;
        do_req(1'b1, 3'b010, 8'hFF, 32'hAABBCCDD, lat, rd, er, oc);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_sw_err: got err=%b, want 0", er);
        end
        do_req(1'b0, 3'b010, 8'hFF, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'hAABBCCDD || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_lw: got RD=%h err=%b, want aabbccdd/0", rd, er);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 3'b100, badr[i], 32'h0, lat, rd, er, oc);
            checks++;
            if (rd !== {24'd0, bexp[i]}) begin
                errors++;
                $display("[TB] FAIL wrap_byte[%h]: got RD=%h, want %h", badr[i], rd, {24'd0, bexp[i]});
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [8:0]  rdy;
        logic [8:0]  rsp;
        logic [31:0] last;
        last = 32'h0;
        WE = 1'b0; funct3 = 3'b010; A = 8'h10; WD = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rdy[i] = req_ready;
            rsp[i] = rsp_valid;
            if (rsp_valid) last = RD;
            if (i == 8) req_valid = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (rdy !== 9'b1_0001_0001) begin
            errors++;
            $display("[TB] FAIL b2b_ready: got %b, want 100010001", rdy);
        end
        checks++;
        if (rsp !== 9'b0_1000_1000) begin
            errors++;
            $display("[TB] FAIL b2b_rsp: got %b, want 010001000", rsp);
        end
        checks++;
        if (last !== 32'h123477EF) begin
            errors++;
            $display("[TB] FAIL b2b_data: got RD=%h, want 123477ef", last);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; logic oc; logic seen;
        do_req(1'b1, 3'b010, 8'h20, 32'h0, lat, rd, er, oc);
        WE = 1'b1; funct3 = 3'b010; A = 8'h20; WD = 32'h11111111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_state: got rsp_valid=%b req_ready=%b, want 0/1", rsp_valid, req_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_norsp: got rsp_valid seen=%b, want 0", seen);
        end
        do_req(1'b0, 3'b010, 8'h20, 32'h0, lat, rd, er, oc);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_nowrite: got RD=%h err=%b, want 00000000/0", rd, er);
        end
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        test_reset();
        test_store_load();
        test_load_ext();
        test_partial_store();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
